// File: rtl/qspi_flash_slave_if.sv
// Bus bundle between a QSPI master / preload agent and qspi_flash_slave.
// The master modport drives the serial lines and the preload port. The slave
// modport returns the data lines, the output enables and the status strobes.
interface qspi_flash_slave_if #(
    parameter int MEM_DEPTH = 4096
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic             sck;
    logic             cs_n;
    logic [3:0]       dq_in;
    logic [3:0]       dq_out;
    logic [3:0]       dq_oe;
    logic             ld_en;
    logic [IDX_W-1:0] ld_addr;
    logic [7:0]       ld_data;
    logic             ld_rej;
    logic             busy;
    logic             cmd_err;

    modport master (
        output sck, cs_n, dq_in, ld_en, ld_addr, ld_data,
        input  dq_out, dq_oe, ld_rej, busy, cmd_err
    );

    modport slave (
        input  sck, cs_n, dq_in, ld_en, ld_addr, ld_data,
        output dq_out, dq_oe, ld_rej, busy, cmd_err
    );
endinterface

// File: rtl/qspi_flash_slave.sv
// QSPI flash read-only slave model backed by a preloadable byte array.
// It supports READ (0x03), FAST_READ (0x0B) and, when the macro
// QSPI_FLASH_QUAD_EN is defined, QUAD OUTPUT READ (0x6B).
// sck, cs_n and dq_in are asynchronous to clk. They are synchronised, and the
// module works from sck edges that it detects on the clk side.
module qspi_flash_slave #(
    parameter int MEM_DEPTH    = 4096,
    parameter int ADDR_W       = 24,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    qspi_flash_slave_if.slave bus
);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int CNT_MAX = (ADDR_W > DUMMY_CYCLES) ? ((ADDR_W > 8) ? ADDR_W : 8)
                                                     : ((DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
`ifdef QSPI_FLASH_QUAD_EN
    localparam logic [7:0] CMD_QUAD_READ = 8'h6B;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

    // Synchroniser and edge-detect state
    logic       sck_meta, sck_sync, sck_prev;
    logic       cs_meta, cs_sync, cs_prev;
    logic [3:0] dq_meta, dq_sync;
    logic [1:0] sync_fill;
    logic       armed;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic       busy;
    logic       dq_sync_unused;

    // FSM and datapath state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       cmd_q, cmd_next;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       dq_out_q, out_d;
    logic             data_oe_q, data_oe_d;
    logic             cmd_err_q, err_d;
    logic             ld_rej_q;
    logic [7:0]       rd_byte;

    // Control strobes from the next-state logic
    logic cnt_clr, cnt_inc, cmd_shift, idx_clr, idx_shift, idx_inc, out_load, last_beat;

    logic [7:0] mem [MEM_DEPTH];

    // Synchronise the async inputs and keep one history flop for edge detection.
    // After reset, armed stays low until a real high cs_n sample has passed the
    // synchroniser. This stops a chip select that was already low from looking
    // like a new falling edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make each stage sample the previous
        // stage's old value. Blocking assignments here would collapse the chain.
        if (rst) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            dq_meta   <= 4'b0000;
            dq_sync   <= 4'b0000;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sck_meta  <= bus.sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            cs_meta   <= bus.cs_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            dq_meta   <= bus.dq_in;
            dq_sync   <= dq_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && cs_sync) begin
                armed <= 1'b1;
            end
        end
    end

    assign sck_rise = sck_sync & ~sck_prev;
    assign sck_fall = ~sck_sync & sck_prev;
    assign cs_fall  = ~cs_sync & cs_prev;
    assign cs_rise  = cs_sync & ~cs_prev;
    // Busy follows the older cs_n copy. A preload in the cycle that detects the
    // falling edge is therefore still accepted.
    assign busy     = ~cs_prev;

    // Command and address arrive on dq_in[0] only. The other lines are
    // synchronised but unused by the supported commands.
    assign dq_sync_unused = ^dq_sync[3:1];

    assign cmd_next = {cmd_q[6:0], dq_sync[0]};
    assign rd_byte  = mem[idx_q];

    function automatic logic cmd_supported(input logic [7:0] cmd);
        logic ok;
        ok = (cmd == CMD_READ) || (cmd == CMD_FAST_READ);
`ifdef QSPI_FLASH_QUAD_EN
        ok = ok || (cmd == CMD_QUAD_READ);
`endif
        return ok;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath control strobes
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // left one unassigned would infer a latch.
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cmd_shift = 1'b0;
        idx_clr   = 1'b0;
        idx_shift = 1'b0;
        idx_inc   = 1'b0;
        out_load  = 1'b0;
        out_d     = 4'b0000;
        last_beat = 1'b0;
        err_d     = 1'b0;

        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall && armed) begin
                        state_d = CMD;
                        cnt_clr = 1'b1;
                        idx_clr = 1'b1;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_shift = 1'b1;
                        if (cnt_q == CMD_LAST) begin
                            cnt_clr = 1'b1;
                            if (cmd_supported(cmd_next)) begin
                                state_d = ADDR;
                            end else begin
                                state_d = IGNORE;
                                err_d   = 1'b1;
                            end
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    // Shifting straight into the byte index keeps only the low
                    // bits, which is the address modulo the array depth.
                    if (sck_rise) begin
                        idx_shift = 1'b1;
                        if (cnt_q == ADDR_LAST) begin
                            cnt_clr = 1'b1;
                            state_d = (cmd_q == CMD_READ || DUMMY_CYCLES == 0) ? DATA : DUMMY;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise) begin
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_clr = 1'b1;
                            state_d = DATA;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                DATA: begin
                    // In DATA, cnt_q points at the next bit or nibble of the
                    // current byte.
                    if (sck_fall) begin
                        out_load = 1'b1;
`ifdef QSPI_FLASH_QUAD_EN
                        if (cmd_q == CMD_QUAD_READ) begin
                            out_d     = cnt_q[0] ? rd_byte[3:0] : rd_byte[7:4];
                            last_beat = cnt_q[0];
                        end else
`endif
                        begin
                            out_d     = {2'b00, rd_byte[3'd7 - cnt_q[2:0]], 1'b0};
                            last_beat = (cnt_q[2:0] == 3'd7);
                        end
                        if (last_beat) begin
                            cnt_clr = 1'b1;
                            idx_inc = 1'b1;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        data_oe_d = (state_d == DATA);
    end

    // Counters, shift registers, output registers and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            cmd_q     <= 8'h00;
            idx_q     <= '0;
            dq_out_q  <= 4'b0000;
            data_oe_q <= 1'b0;
            cmd_err_q <= 1'b0;
            ld_rej_q  <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (cmd_shift) begin
                cmd_q <= cmd_next;
            end

            if (idx_clr) begin
                idx_q <= '0;
            end else if (idx_shift) begin
                idx_q <= {idx_q[IDX_W-2:0], dq_sync[0]};
            end else if (idx_inc) begin
                idx_q <= idx_q + IDX_W'(1);
            end

            if (state_d != DATA) begin
                dq_out_q <= 4'b0000;
            end else if (out_load) begin
                dq_out_q <= out_d;
            end

            data_oe_q <= data_oe_d;
            cmd_err_q <= err_d;
            ld_rej_q  <= bus.ld_en & busy;
        end
    end

    // Preload port: writes are accepted only while no transfer is in progress
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch. Reset must not disturb preloaded
        // contents, and leaving it out also lets the array map onto RAM.
        if (bus.ld_en && !busy) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    assign bus.dq_out  = dq_out_q;
`ifdef QSPI_FLASH_QUAD_EN
    assign bus.dq_oe   = (cmd_q == CMD_QUAD_READ) ? {4{data_oe_q}} : {2'b00, data_oe_q, 1'b0};
`else
    assign bus.dq_oe   = {2'b00, data_oe_q, 1'b0};
`endif
    assign bus.busy    = busy;
    assign bus.cmd_err = cmd_err_q;
    assign bus.ld_rej  = ld_rej_q;
endmodule

// File: tb/tb_qspi_flash_slave.sv
// Scoreboard bench for qspi_flash_slave.
// The stimulus process plays a mode-0 QSPI master and queues the expected data
// beats and status events. Two monitors pop and compare: one on every master
// sck rise while dq_oe is active, and one on every cmd_err or ld_rej pulse.
`timescale 1ns/1ps
module tb_qspi_flash_slave;
    localparam int MEM_DEPTH    = 4096;
    localparam int ADDR_W       = 24;
    localparam int DUMMY_CYCLES = 8;
    localparam int HALF         = 5;   // sck half period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qspi_flash_slave_if #(.MEM_DEPTH(MEM_DEPTH)) bus ();

    qspi_flash_slave #(
        .MEM_DEPTH   (MEM_DEPTH),
        .ADDR_W      (ADDR_W),
        .DUMMY_CYCLES(DUMMY_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [3:0] oe;
        logic [3:0] dq;
    } beat_t;

    typedef enum logic {EV_CMD_ERR, EV_LD_REJ} ev_t;

    beat_t exp_beat_q[$];
    ev_t   exp_ev_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic take_beat(input beat_t got);
        beat_t e;
        if (exp_beat_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got oe=0x%0h dq=0x%0h, expected no output", got.oe, got.dq);
        end else begin
            e = exp_beat_q.pop_front();
            check("data_beat", 32'(got), 32'(e));
        end
    endtask

    task automatic take_event(input ev_t got);
        ev_t e;
        if (exp_ev_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got %s, expected none", got.name());
        end else begin
            e = exp_ev_q.pop_front();
            check("event_kind", 32'(got), 32'(e));
        end
    endtask

    // Data monitor: the master samples on its own rising sck edge
    initial begin
        forever begin
            @(posedge bus.sck);
            if (bus.dq_oe !== 4'b0000) begin
                take_beat({bus.dq_oe, bus.dq_out});
            end
        end
    end

    // Status monitor: pulses are sampled on the falling clk edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.cmd_err === 1'b1) take_event(EV_CMD_ERR);
            if (!rst && bus.ld_rej === 1'b1)  take_event(EV_LD_REJ);
        end
    end

    // Watchdog
    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_cycle(input logic [3:0] d);
        bus.dq_in = d;
        wait_clk(HALF);
        bus.sck = 1'b1;
        wait_clk(HALF);
        bus.sck = 1'b0;
    endtask

    task automatic begin_xfer(input logic [7:0] cmd, input logic [23:0] addr,
                              input int nbits, input int dummies);
        bus.cs_n = 1'b0;
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, cmd[i]});
        for (int i = 0; i < nbits; i++) sck_cycle({3'b000, addr[23-i]});
        repeat (dummies) sck_cycle(4'b0000);
    endtask

    task automatic data_clocks(input int n);
        repeat (n) sck_cycle(4'b0000);
    endtask

    task automatic end_xfer();
        wait_clk(HALF);
        bus.cs_n  = 1'b1;
        bus.dq_in = 4'b0000;
        wait_clk(8);
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        wait_clk(1);
        bus.ld_en   = 1'b0;
    endtask

    task automatic expect_single(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_beat_q.push_back(beat_t'({4'b0010, 2'b00, b[i], 1'b0}));
    endtask

    task automatic expect_quad(input logic [7:0] b);
        exp_beat_q.push_back(beat_t'({4'b1111, b[7:4]}));
        exp_beat_q.push_back(beat_t'({4'b1111, b[3:0]}));
    endtask

    initial begin
        bus.sck     = 1'b0;
        bus.cs_n    = 1'b1;
        bus.dq_in   = 4'b0000;
        bus.ld_en   = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = 8'h00;

        // Reset values
        rst = 1'b1;
        wait_clk(3);
        check("rst_dq_oe",   32'(bus.dq_oe),   32'h0);
        check("rst_dq_out",  32'(bus.dq_out),  32'h0);
        check("rst_busy",    32'(bus.busy),    32'h0);
        check("rst_cmd_err", 32'(bus.cmd_err), 32'h0);
        check("rst_ld_rej",  32'(bus.ld_rej),  32'h0);
        rst = 1'b0;
        wait_clk(4);

        preload(12'h010, 8'hA5);
        preload(12'hFFE, 8'h11);
        preload(12'hFFF, 8'h22);
        preload(12'h000, 8'h33);
        preload(12'h100, 8'h12);
        preload(12'h101, 8'h34);
        wait_clk(2);

        // Plain read of one byte
        expect_single(8'hA5);
        begin_xfer(8'h03, 24'h000010, 24, 0);
        check("busy_in_xfer", 32'(bus.busy), 32'h1);
        data_clocks(8);
        end_xfer();
        check("busy_after_xfer", 32'(bus.busy), 32'h0);

        // Fast read across the top of the array, with wrap to 0
        expect_single(8'h11);
        expect_single(8'h22);
        expect_single(8'h33);
        begin_xfer(8'h0B, 24'hFFFFFE, 24, DUMMY_CYCLES);
        data_clocks(24);
        end_xfer();

        // Quad read, or rejection of 0x6B when quad support is not built in
`ifdef QSPI_FLASH_QUAD_EN
        expect_quad(8'h12);
        expect_quad(8'h34);
        begin_xfer(8'h6B, 24'h000100, 24, DUMMY_CYCLES);
        data_clocks(4);
        end_xfer();
`else
        exp_ev_q.push_back(EV_CMD_ERR);
        begin_xfer(8'h6B, 24'h000100, 24, DUMMY_CYCLES);
        data_clocks(4);
        check("oe_quad_disabled", 32'(bus.dq_oe), 32'h0);
        end_xfer();
`endif

        // Unsupported command, then a normal read
        exp_ev_q.push_back(EV_CMD_ERR);
        begin_xfer(8'h9F, 24'h000010, 24, 0);
        data_clocks(8);
        check("oe_in_ignore", 32'(bus.dq_oe), 32'h0);
        end_xfer();
        expect_single(8'hA5);
        begin_xfer(8'h03, 24'h000010, 24, 0);
        data_clocks(8);
        end_xfer();

        // Abort after 12 address bits, then a fresh read
        begin_xfer(8'h03, 24'hFFFFFF, 12, 0);
        end_xfer();
        expect_single(8'hA5);
        begin_xfer(8'h03, 24'h000010, 24, 0);
        data_clocks(8);
        end_xfer();

        // A preload while busy is dropped, and the byte read in the same transfer is unchanged
        exp_ev_q.push_back(EV_LD_REJ);
        expect_single(8'hA5);
        begin_xfer(8'h03, 24'h000010, 24, 0);
        preload(12'h010, 8'h00);
        data_clocks(8);
        end_xfer();

        // Reset in DATA: outputs drop on the next clk and stay quiet while cs_n is still low
        expect_single(8'hA5);
        repeat (5) void'(exp_beat_q.pop_back());   // only the first three bits get clocked
        begin_xfer(8'h03, 24'h000010, 24, 0);
        data_clocks(3);
        wait_clk(1);
        rst = 1'b1;
        wait_clk(1);
        check("oe_after_rst", 32'(bus.dq_oe), 32'h0);
        rst = 1'b0;
        data_clocks(4);
        check("oe_after_rst_held", 32'(bus.dq_oe), 32'h0);
        end_xfer();

        // Memory survives reset
        expect_single(8'h11);
        expect_single(8'h22);
        begin_xfer(8'h03, 24'h000FFE, 24, 0);
        data_clocks(16);
        end_xfer();

        wait_clk(10);
        check("beat_queue_drained",  32'(exp_beat_q.size()), 32'h0);
        check("event_queue_drained", 32'(exp_ev_q.size()),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/qspi_flash_slave.md
QSPI_FLASH_SLAVE -- requirements
Module: qspi_flash_slave

Interface
REQ-001 Parameter MEM_DEPTH, default 4096, byte capacity of the internal array; power of two.
REQ-002 Parameter ADDR_W, default 24, number of address bits shifted in after the command.
REQ-003 Parameter DUMMY_CYCLES, default 8, sck cycles between the last address bit and the first data bit for fast and quad reads.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 sck  in  1  serial clock, asynchronous to clk, at most clk/4.
REQ-007 cs_n  in  1  chip select, active-low, asynchronous.
REQ-008 dq_in  in  4  serial data lines from the master; only dq_in[0] is used for command and address.
REQ-009 dq_out  out  4  serial data driven to the master.
REQ-010 dq_oe  out  4  per-line output enable for dq_out.
REQ-011 ld_en  in  1  preload write strobe.
REQ-012 ld_addr  in  log2(MEM_DEPTH)  preload byte address.
REQ-013 ld_data  in  8  preload byte.
REQ-014 ld_rej  out  1  one-cycle pulse: preload write was dropped.
REQ-015 busy  out  1  high whenever the synchronised cs_n is low.
REQ-016 cmd_err  out  1  one-cycle pulse: an unsupported command byte was received.

Function
REQ-017 Synchronisation: sck, cs_n and dq_in each pass through a 2-flop synchroniser.
REQ-018 Edge detection: sck edges are detected on the synchronised copies; input is sampled on the rising sck edge and output is updated on the falling sck edge.
REQ-019 States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
REQ-020 IDLE->CMD: on the synchronised cs_n falling edge, with the bit counter cleared.
REQ-021 CMD: shift 8 bits from dq_in[0], MSB first; after the 8th bit go to ADDR for 0x03, 0x0B and 0x6B, otherwise go to IGNORE and pulse cmd_err.
REQ-022 ADDR: shift ADDR_W bits, MSB first; the byte index is address mod MEM_DEPTH.
REQ-023 ADDR exit: go to DATA for 0x03; go to DUMMY for 0x0B and 0x6B.
REQ-024 DUMMY: count DUMMY_CYCLES rising sck edges, then go to DATA; DUMMY_CYCLES=0 goes directly to DATA.
REQ-025 DATA, single mode (0x03/0x0B): dq_oe=4'b0010; one bit per falling edge on dq_out[1], MSB first.
REQ-026 DATA, quad mode (0x6B): dq_oe=4'b1111; one nibble per falling edge on dq_out[3:0], high nibble first.
REQ-027 The first data bit or nibble appears on the first falling sck edge after the final address or dummy rising edge.
REQ-028 After each byte, the index increments and wraps from MEM_DEPTH-1 to 0; the read continues until cs_n rises.
REQ-029 IGNORE: dq_oe=0; all sck activity is ignored until cs_n rises.
REQ-030 The synchronised cs_n rising edge in any state forces IDLE on the next clk and clears dq_oe, which aborts any partial command, address or byte.
REQ-031 Preload: when ld_en=1 and busy=0, write ld_data to mem[ld_addr] on that clk.
REQ-032 When ld_en=1 and busy=1, the write is dropped and ld_rej pulses.
REQ-033 A preload in the same clk as the cs_n falling-edge detection is accepted, because busy is still 0.
REQ-034 Unused dq_out bits are 0.

Reset
REQ-035 rst forces: state IDLE, counters 0, dq_oe=0, dq_out=0, ld_rej=0, cmd_err=0, busy=0, synchronisers to idle values (cs_n=1, sck=0).
REQ-036 Memory contents are not altered by rst.
REQ-037 rst asserted mid-transfer aborts it; no further output is produced until a new cs_n falling edge.

Configuration
REQ-038 Macro QSPI_FLASH_QUAD_EN defined: command 0x6B is supported as quad output read.
REQ-039 Macro QSPI_FLASH_QUAD_EN undefined: 0x6B is unsupported (IGNORE plus cmd_err), dq_oe[3:2] and dq_oe[0] are tied 0, and the quad datapath is absent.

Verification
REQ-040 Preload mem[0x010]=0xA5; send 0x03 with addr 0x000010 -> dq_out[1] gives 1,0,1,0,0,1,0,1 with dq_oe=4'b0010.
REQ-041 Preload mem[4094]=0x11 and mem[4095]=0x22 (mem[0]=0x33); send 0x0B with addr 0xFFFFFE, 8 dummy cycles, 24 data clocks -> bytes 0x11, 0x22, 0x33 (wrap).
REQ-042 QUAD_EN defined; mem[0x100]=0x12, mem[0x101]=0x34; send 0x6B with addr 0x000100 -> nibbles 1,2,3,4 with dq_oe=4'hF; with QUAD_EN undefined -> cmd_err pulse and dq_oe stays 0.
REQ-043 Send command 0x9F -> cmd_err pulses once, dq_oe stays 0 until cs_n rises, and the next 0x03 transfer works normally.
REQ-044 Raise cs_n after 12 address bits, then issue a new 0x03 with addr 0x000010 -> correct byte 0xA5 (no stale address bits).
REQ-045 Assert ld_en while busy -> ld_rej pulses and memory is unchanged; assert rst during DATA -> dq_oe=0 on the next clk.
